dual_rail_driver: RTL and testbench

- Clocked transmitter for the asynchronous dual-rail link; the sending end of the channel watched by the dual-rail monitor and completion C-element collectors.
- Accepts WIDTH-bit tokens on a valid/ready interface and encodes each one onto the dual-rail rails, in two-phase (TP) or four-phase return-to-zero (FP) encoding.
- Holds off the next token until the receiver's acknowledge has been synchronised and seen.

---
 rtl/dual_rail_pkg.sv | 27 ++
 rtl/ack_sync.sv | 24 ++
 rtl/dual_rail_driver.sv | 151 +++++++++++++++
 tb/tb_dual_rail_driver.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/dual_rail_pkg.sv
// Shared types and constants for the dual-rail link transmitter.
package dual_rail_pkg;

  // Rails per data bit and their indices within a bit's rail pair.
  localparam int unsigned RAIL_NUM  = 2;
  localparam int unsigned RAIL_ZERO = 0;
  localparam int unsigned RAIL_ONE  = 1;

  typedef enum logic {
    ENC_TP,
    ENC_FP
  } enc_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    WAIT_SET,
    WAIT_CLR
  } state_t;

  // Maps the two-character encoding name onto enc_t; unknown names fall back to TP
  // and are rejected separately at elaboration.
  function automatic enc_t str_to_enc(input logic [15:0] s);
    return (s == "FP") ? ENC_FP : ENC_TP;
  endfunction

endpackage

// File: rtl/ack_sync.sv
// Multi-flop synchroniser for the asynchronous acknowledge; synchronous reset to 0.
module ack_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sync
);

  logic [SYNC_STAGES-1:0] r_sync;

  // Shift the raw ack through the flop chain; the last stage is the safe copy.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/dual_rail_driver.sv
// Clocked dual-rail link transmitter (two-phase or four-phase RZ encoding).
// Optional ack watchdog enabled by defining DUAL_RAIL_DRIVER_TIMEOUT_EN.
module dual_rail_driver
  import dual_rail_pkg::*;
#(
  parameter logic [15:0] ENC         = "TP",
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [WIDTH-1:0]               in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [WIDTH-1:0][RAIL_NUM-1:0] out,
  input  logic                           ack,
  output logic                           busy
`ifdef DUAL_RAIL_DRIVER_TIMEOUT_EN
  ,
  output logic                           timeout_err
`endif
);

  localparam enc_t EncSel = str_to_enc(ENC);

  if (ENC != "TP" && ENC != "FP") begin : g_bad_enc
    $error("dual_rail_driver: ENC must be \"TP\" or \"FP\"");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("dual_rail_driver: SYNC_STAGES must be at least 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("dual_rail_driver: TIMEOUT must be at least 1");
  end

  state_t                         r_state;
  logic                           r_in_ready;
  logic                           r_ack_ref;
  logic [WIDTH-1:0][RAIL_NUM-1:0] r_out;
  logic [WIDTH-1:0][RAIL_NUM-1:0] w_set_rails;
  logic                           w_ack_s;
  logic                           w_accept;

  ack_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_async(ack),
    .o_sync (w_ack_s)
  );

  // in_ready is only ever high in IDLE, so it alone qualifies acceptance.
  assign w_accept = in_valid && r_in_ready;

  // One-hot rail pair per bit: the rail named by the data bit is selected.
  always_comb begin
    w_set_rails = '0;
    for (int b = 0; b < WIDTH; b++) begin
      w_set_rails[b][RAIL_ONE]  = in_data[b];
      w_set_rails[b][RAIL_ZERO] = !in_data[b];
    end
  end

  // Handshake FSM; rails, ready and ack phase reference are all registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_out      <= '0;
      r_in_ready <= 1'b0;
      r_ack_ref  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_in_ready <= 1'b0;
            if (EncSel == ENC_TP) begin
              // Toggle the selected rail of each bit; the other rail holds.
              r_out     <= r_out ^ w_set_rails;
              r_ack_ref <= !r_ack_ref;
              r_state   <= WAIT_ACK;
            end else begin
              r_out   <= w_set_rails;
              r_state <= WAIT_SET;
            end
          end
        end
        WAIT_ACK: begin
          if (w_ack_s == r_ack_ref) begin
            r_state    <= IDLE;
            r_in_ready <= 1'b1;
          end
        end
        WAIT_SET: begin
          if (w_ack_s) begin
            r_out   <= '0;
            r_state <= WAIT_CLR;
          end
        end
        WAIT_CLR: begin
          if (!w_ack_s) begin
            r_state    <= IDLE;
            r_in_ready <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out      = r_out;
  assign in_ready = r_in_ready;
  assign busy     = (r_state != IDLE);

`ifdef DUAL_RAIL_DRIVER_TIMEOUT_EN
  localparam int unsigned    CntW   = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

  logic [CntW-1:0]  r_cnt;
  logic [CntW-1:0]  w_cnt_inc;
  logic             r_timeout_err;
  logic [WIDTH-1:0] r_token;

  assign w_cnt_inc = r_cnt + CntW'(1);

  // Watchdog: counts wait cycles per token, saturates, flags once; FSM is unaffected.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
      r_token       <= '0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_token <= in_data;
    end else if (r_state != IDLE && r_cnt != CntMax) begin
      r_cnt <= w_cnt_inc;
      if (w_cnt_inc == CntMax) begin
        r_timeout_err <= 1'b1;
`ifndef SYNTHESIS
        $display("dual_rail_driver: ack timeout on token %h", r_token);
`endif
      end
    end
  end

  assign timeout_err = r_timeout_err;
`endif

endmodule

// File: tb/tb_dual_rail_driver.sv
// Directed bench for dual_rail_driver: one TP instance (WIDTH=4) and one FP instance (WIDTH=2).
module tb_dual_rail_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [3:0]      tp_data;
  logic            tp_valid, tp_ready, tp_ack, tp_busy;
  logic [3:0][1:0] tp_out;
  logic [1:0]      fp_data;
  logic            fp_valid, fp_ready, fp_ack, fp_busy;
  logic [1:0][1:0] fp_out;
`ifdef DUAL_RAIL_DRIVER_TIMEOUT_EN
  logic            tp_err, fp_err;
`endif

  int total = 0;
  int bad   = 0;

  dual_rail_driver #(
    .ENC("TP"), .WIDTH(4), .SYNC_STAGES(2), .TIMEOUT(16)
  ) u_tp (
    .clk(clk), .rst(rst), .in_data(tp_data), .in_valid(tp_valid), .in_ready(tp_ready),
    .out(tp_out), .ack(tp_ack), .busy(tp_busy)
`ifdef DUAL_RAIL_DRIVER_TIMEOUT_EN
    , .timeout_err(tp_err)
`endif
  );

  dual_rail_driver #(
    .ENC("FP"), .WIDTH(2), .SYNC_STAGES(2), .TIMEOUT(16)
  ) u_fp (
    .clk(clk), .rst(rst), .in_data(fp_data), .in_valid(fp_valid), .in_ready(fp_ready),
    .out(fp_out), .ack(fp_ack), .busy(fp_busy)
`ifdef DUAL_RAIL_DRIVER_TIMEOUT_EN
    , .timeout_err(fp_err)
`endif
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Token recovered from a TP rail change: one-rail toggles mark the 1 bits.
  function automatic logic [3:0] dec_tp(input logic [7:0] cur, input logic [7:0] old);
    logic [7:0] d;
    logic [3:0] r;
    d = cur ^ old;
    for (int b = 0; b < 4; b++) r[b] = d[2*b+1];
    return r;
  endfunction

  logic [7:0] prev;
  logic [3:0] toks [3];
  logic [7:0] outs [3];

  initial begin
    toks[0] = 4'h0; toks[1] = 4'hF; toks[2] = 4'h5;
    outs[0] = 8'hCC; outs[1] = 8'h66; outs[2] = 8'h00;
    rst = 1'b1;
    tp_data = '0; tp_valid = 1'b0; tp_ack = 1'b0;
    fp_data = '0; fp_valid = 1'b0; fp_ack = 1'b0;

    // Reset
    step(1);
    chk("rst_tp_out", 32'(tp_out), 32'h0);
    chk("rst_tp_ready", 32'(tp_ready), 32'h0);
    step(2);
    chk("rst_fp_out", 32'(fp_out), 32'h0);
    chk("rst_tp_busy", 32'(tp_busy), 32'h0);
    chk("rst_fp_ready", 32'(fp_ready), 32'h0);
    rst = 1'b0;
    step(1);
    chk("rel_tp_ready", 32'(tp_ready), 32'h1);
    chk("rel_fp_ready", 32'(fp_ready), 32'h1);
`ifdef DUAL_RAIL_DRIVER_TIMEOUT_EN
    chk("rel_tp_err", 32'(tp_err), 32'h0);
`endif

    // TP single token 4'hA
    prev = 32'(tp_out) & 8'hFF;
    tp_data = 4'hA; tp_valid = 1'b1;
    step(1);
    tp_valid = 1'b0;
    chk("tpA_out", 32'(tp_out), 32'h99);
    chk("tpA_dec", 32'(dec_tp(tp_out, prev)), 32'hA);
    chk("tpA_trans", 32'($countones(tp_out ^ prev)), 32'd4);
    chk("tpA_busy", 32'(tp_busy), 32'h1);
    $display("monitor: %h", dec_tp(tp_out, prev));
    tp_ack = 1'b1;
    step(2);
    chk("tpA_ready_early", 32'(tp_ready), 32'h0);
    step(1);
    chk("tpA_ready", 32'(tp_ready), 32'h1);
    chk("tpA_idle", 32'(tp_busy), 32'h0);

    // TP back-to-back with in_valid held high
    tp_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      prev = tp_out;
      tp_data = toks[i];
      step(1);
      chk("b2b_out", 32'(tp_out), 32'(outs[i]));
      chk("b2b_dec", 32'(dec_tp(tp_out, prev)), 32'(toks[i]));
      chk("b2b_trans", 32'($countones(tp_out ^ prev)), 32'd4);
      $display("monitor: %h", dec_tp(tp_out, prev));
      prev = tp_out;
      tp_data = 4'h9;  // must not be sampled while busy
      tp_ack = ~tp_ack;
      step(2);
      chk("b2b_hold", 32'(tp_out), 32'(prev));
      chk("b2b_notready", 32'(tp_ready), 32'h0);
      step(1);
      chk("b2b_ready", 32'(tp_ready), 32'h1);
      chk("b2b_hold2", 32'(tp_out), 32'(prev));
    end
    tp_valid = 1'b0;

    // Reset mid-token, then deliver 4'hC
    tp_data = 4'h3; tp_valid = 1'b1;
    step(1);
    tp_valid = 1'b0;
    chk("mid_out", 32'(tp_out), 32'h5A);
    chk("mid_busy", 32'(tp_busy), 32'h1);
    rst = 1'b1;
    step(1);
    chk("mid_rst_out", 32'(tp_out), 32'h0);
    chk("mid_rst_busy", 32'(tp_busy), 32'h0);
    rst = 1'b0; tp_ack = 1'b0;
    step(1);
    chk("mid_ready", 32'(tp_ready), 32'h1);
    tp_data = 4'hC; tp_valid = 1'b1;
    step(1);
    tp_valid = 1'b0;
    chk("c_out", 32'(tp_out), 32'hA5);
    chk("c_dec", 32'(dec_tp(tp_out, 8'h00)), 32'hC);
    tp_ack = 1'b1;
    step(3);
    chk("c_ready", 32'(tp_ready), 32'h1);

    // FP token 2'b10
    fp_data = 2'b10; fp_valid = 1'b1;
    step(1);
    fp_valid = 1'b0;
    chk("fp_out", 32'(fp_out), 32'h9);
    chk("fp_busy", 32'(fp_busy), 32'h1);
    fp_ack = 1'b1;
    step(2);
    chk("fp_hold", 32'(fp_out), 32'h9);
    step(1);
    chk("fp_spacer", 32'(fp_out), 32'h0);
    chk("fp_clr_notready", 32'(fp_ready), 32'h0);
    fp_ack = 1'b0;
    step(2);
    chk("fp_ready_early", 32'(fp_ready), 32'h0);
    step(1);
    chk("fp_ready", 32'(fp_ready), 32'h1);
    chk("fp_idle", 32'(fp_busy), 32'h0);

    // Spurious ack pulse while IDLE
    fp_ack = 1'b1;
    step(4);
    fp_ack = 1'b0;
    step(4);
    chk("spur_out", 32'(fp_out), 32'h0);
    chk("spur_ready", 32'(fp_ready), 32'h1);
    chk("spur_busy", 32'(fp_busy), 32'h0);

    // FP token 2'b01 after the spurious pulse
    fp_data = 2'b01; fp_valid = 1'b1;
    step(1);
    fp_valid = 1'b0;
    chk("fp2_out", 32'(fp_out), 32'h6);
    fp_ack = 1'b1;
    step(3);
    chk("fp2_spacer", 32'(fp_out), 32'h0);
    fp_ack = 1'b0;
    step(3);
    chk("fp2_ready", 32'(fp_ready), 32'h1);

`ifdef DUAL_RAIL_DRIVER_TIMEOUT_EN
    // Watchdog: ack phase left unchanged after accept
    tp_data = 4'h1; tp_valid = 1'b1;
    step(1);
    tp_valid = 1'b0;
    step(15);
    chk("to_not_yet", 32'(tp_err), 32'h0);
    step(1);
    chk("to_set", 32'(tp_err), 32'h1);
    step(5);
    chk("to_sticky", 32'(tp_err), 32'h1);
    chk("to_still_busy", 32'(tp_busy), 32'h1);
    tp_ack = 1'b0;
    step(3);
    chk("to_late_ready", 32'(tp_ready), 32'h1);
    chk("to_err_kept", 32'(tp_err), 32'h1);
    chk("to_fp_err", 32'(fp_err), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
